// File: rtl/pipo_pkg.sv
// Shared definitions for the pipo_register slice: default lane count and lane-index enum.
package pipo_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        LANE_A = 2'd0,
        LANE_B = 2'd1,
        LANE_C = 2'd2,
        LANE_D = 2'd3
    } lane_e;

endpackage

// File: rtl/pipo_bit_cell.sv
// Single-lane async-reset storage flop with load enable.
// With PIPO_SHIFT_EN defined, a shift input is muxed in at lower priority than load.
module pipo_bit_cell
    import pipo_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic rst_n,
    input  logic load_en,
    input  logic d,
`ifdef PIPO_SHIFT_EN
    input  logic shift_en,
    input  logic ser_in,
`endif
    output logic q
);

    logic r_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= RST_VAL;
        end else if (load_en) begin
            r_q <= d;
`ifdef PIPO_SHIFT_EN
        end else if (shift_en) begin
            r_q <= ser_in;
`endif
        end
    end

    assign q = r_q;

endmodule

// File: rtl/pipo_register.sv
// Parameterised parallel-in/parallel-out register built from WIDTH pipo_bit_cell lanes.
// Optional serial shift path (toward the MSB) enabled by defining PIPO_SHIFT_EN.
module pipo_register
    import pipo_pkg::*;
#(
    parameter int unsigned          WIDTH     = DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [WIDTH-1:0] din,
`ifdef PIPO_SHIFT_EN
    input  logic             shift_en,
    input  logic             ser_in,
    output logic             ser_out,
`endif
    output logic [WIDTH-1:0] q,
    output logic             q_valid
);

    logic [WIDTH-1:0] w_q;
    logic             r_valid;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
`ifdef PIPO_SHIFT_EN
        // Lane 0 takes the serial input; every other lane takes its lower neighbour.
        logic w_ser;
        if (i == 0) begin : g_first
            assign w_ser = ser_in;
        end else begin : g_chain
            assign w_ser = w_q[i-1];
        end
`endif
        pipo_bit_cell #(
            .RST_VAL (RESET_VAL[i])
        ) u_cell (
            .clock    (clock),
            .rst_n    (rst_n),
            .load_en  (load_en),
            .d        (din[i]),
`ifdef PIPO_SHIFT_EN
            .shift_en (shift_en),
            .ser_in   (w_ser),
`endif
            .q        (w_q[i])
        );
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
        end else if (load_en) begin
            r_valid <= 1'b1;
        end
    end

    assign q       = w_q;
    assign q_valid = r_valid;
`ifdef PIPO_SHIFT_EN
    assign ser_out = w_q[WIDTH-1];
`endif

endmodule

// File: tb/tb_pipo_register.sv
// Self-checking bench for pipo_register: directed steps then random traffic vs a behavioural model.
// Shift checks are compiled in when PIPO_SHIFT_EN is defined.
module tb_pipo_register;
    import pipo_pkg::*;

    localparam int unsigned W = 4;

    logic         clock = 1'b0;
    logic         rst_n;
    logic         load_en;
    logic [W-1:0] din;
    logic [W-1:0] q;
    logic         q_valid;
`ifdef PIPO_SHIFT_EN
    logic         shift_en;
    logic         ser_in;
    logic         ser_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural reference state
    logic [W-1:0] m_q;
    logic         m_v;

    pipo_register #(
        .WIDTH     (W),
        .RESET_VAL ('0)
    ) dut (
        .clock    (clock),
        .rst_n    (rst_n),
        .load_en  (load_en),
        .din      (din),
`ifdef PIPO_SHIFT_EN
        .shift_en (shift_en),
        .ser_in   (ser_in),
        .ser_out  (ser_out),
`endif
        .q        (q),
        .q_valid  (q_valid)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Wait for the next rising edge and settle away from it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        load_en = 1'b1;
        din     = 4'hF;
`ifdef PIPO_SHIFT_EN
        shift_en = 1'b0;
        ser_in   = 1'b0;
`endif
        #1;
        check("reset_q_async", q, 4'h0);
        check("reset_v_async", {3'b0, q_valid}, 4'h0);
        tick();
        tick();
        check("reset_q_edges", q, 4'h0);
        check("reset_v_edges", {3'b0, q_valid}, 4'h0);

        // Basic load on first edge after release
        rst_n   = 1'b1;
        din     = 4'b1010;
        load_en = 1'b1;
        tick();
        check("load_q", q, 4'hA);
        check("load_v", {3'b0, q_valid}, 4'h1);
        check("load_laneD", {3'b0, q[LANE_D]}, 4'h1);
        check("load_laneA", {3'b0, q[LANE_A]}, 4'h0);

        // Hold while din toggles
        load_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            case (i % 3)
                0:       din = 4'h0;
                1:       din = 4'hF;
                default: din = 4'h5;
            endcase
            tick();
        end
        check("hold_q", q, 4'hA);
        din = 'x;
        tick();
        check("hold_x_din", q, 4'hA);

        // Back-to-back loads
        load_en = 1'b1;
        din = 4'h3; tick(); check("b2b_0", q, 4'h3);
        din = 4'hC; tick(); check("b2b_1", q, 4'hC);
        din = 4'h9; tick(); check("b2b_2", q, 4'h9);
        load_en = 1'b0;
        tick();
        check("b2b_hold", q, 4'h9);

        // Mid-op reset between edges, with load pending
        load_en = 1'b1;
        din     = 4'hE;
        #3;
        rst_n = 1'b0;
        #1;
        check("midrst_q", q, 4'h0);
        check("midrst_v", {3'b0, q_valid}, 4'h0);
        tick();
        check("midrst_edge_q", q, 4'h0);
        rst_n = 1'b1;
        din   = 4'h6;
        tick();
        check("post_rst_load", q, 4'h6);
        check("post_rst_v", {3'b0, q_valid}, 4'h1);

`ifdef PIPO_SHIFT_EN
        din = 4'b0001; load_en = 1'b1; tick();
        load_en = 1'b0; shift_en = 1'b1; ser_in = 1'b1;
        tick(); check("shift_1", q, 4'b0011);
        tick(); check("shift_2", q, 4'b0111);
        tick(); check("shift_3", q, 4'b1111);
        check("ser_out", {3'b0, ser_out}, 4'h1);
        load_en = 1'b1; din = 4'h2;
        tick(); check("load_prio", q, 4'h2);
        shift_en = 1'b0;
`endif

        // Randomised traffic against the model
        m_q = q;
        m_v = q_valid;
        for (int i = 0; i < 300; i++) begin
            rst_n   = ($urandom_range(0, 19) != 0);
            load_en = $urandom_range(0, 2) == 0;
            din     = load_en ? W'($urandom) : 'x;
`ifdef PIPO_SHIFT_EN
            shift_en = $urandom_range(0, 1) == 1;
            ser_in   = $urandom_range(0, 1) == 1;
`endif
            #1;
            if (!rst_n) begin
                m_q = '0;
                m_v = 1'b0;
                check("rnd_async_rst", q, m_q);
            end
            @(posedge clock);
            if (rst_n) begin
                if (load_en) begin
                    m_q = din;
                    m_v = 1'b1;
`ifdef PIPO_SHIFT_EN
                end else if (shift_en) begin
                    m_q = W'((m_q * 2) + ser_in);
`endif
                end
            end
            #1;
            check("rnd_q", q, m_q);
            check("rnd_v", {3'b0, q_valid}, {3'b0, m_v});
`ifdef PIPO_SHIFT_EN
            check("rnd_ser_out", {3'b0, ser_out}, {3'b0, m_q[W-1]});
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipo_register.md
Name: pipo_register

Overview:
- Parameterised parallel-in/parallel-out storage register: captures a WIDTH-bit word on a clock edge when load is enabled and holds it otherwise.
- Replaces the transistor-level gated-latch PIPO cell (per-bit NAND-latch built from nmos/pmos) with a synchronous edge-triggered equivalent.
- Sits between a parallel source bus and downstream parallel consumers.
- Lane order: bit0=A, bit1=B, bit2=C, bit3=D.

Parameters:
- WIDTH, 4, number of data lanes (min 1).
- RESET_VAL, 0 (WIDTH bits), value loaded into q on reset.

Ports:
- clock  input  1  single system clock, rising-edge active.
- rst_n  input  1  asynchronous active-low reset.
- load_en  input  1  capture strobe; high = load din on next rising edge.
- din  input  WIDTH  parallel data in (bit0=A … bit3=D).
- q  output  WIDTH  parallel data out (bit0=out1 … bit3=out4).
- q_valid  output  1  high once at least one load has completed since reset.

Behaviour:
- One clock (clock). Reset is asynchronous and active-low (rst_n).
- While rst_n=0: q=RESET_VAL and q_valid=0 immediately, independent of clock. Reset release is synchronous-safe: the first capture can happen on the first rising edge after rst_n rises.
- Rising edge with load_en=1: q<=din and q_valid<=1. Latency is 1 cycle from din/load_en sampled to q.
- Rising edge with load_en=0: q and q_valid hold.
- din changes while load_en=0 have no effect on q. There is no transparency, unlike the latch original.
- Back-to-back loads on consecutive cycles are each captured. The last value wins and there is no overflow concept.
- Reset asserted mid-operation, including the same cycle as load_en=1: reset wins.
- All lanes are captured atomically on the same edge. No per-lane enable.
- No combinational path from any input to any output. Outputs are driven directly from flops.
- X on din when load_en=0 must not propagate.

Optional Feature:
- Macro: PIPO_SHIFT_EN.
- Defined: adds inputs shift_en (1) and ser_in (1), and output ser_out (1).
  - On a rising edge with load_en=0 and shift_en=1: q<={q[WIDTH-2:0], ser_in}.
  - ser_out=q[WIDTH-1].
  - load_en has priority over shift_en.
  - Reset clears any shift in progress.
  - For WIDTH=1, q<=ser_in.
- Undefined: none of these ports exist. Behaviour is pure PIPO as specified above.

Decomposition:
- Shared package pipo_pkg holds:
  - localparam DEFAULT_WIDTH=4.
  - A typedef for the lane-index enum (LANE_A=0, LANE_B, LANE_C, LANE_D) used by benches and integrators.
- One natural sub-module: pipo_bit_cell, a single-bit async-reset flop with load and optional shift mux.
  - Instantiated WIDTH times via generate.
  - The top adds the q_valid flop and the port wiring.

Test Plan:
- Reset: rst_n=0 with din=4'hF and load_en=1 -> q=4'h0 and q_valid=0 with no clock edge required. Both stay so through edges while rst_n=0.
- Basic load: release reset, din=4'b1010 (D=1,C=0,B=1,A=0), load_en=1 for one edge -> next cycle q=4'b1010, q_valid=1.
- Hold: after q=4'hA, set load_en=0 and toggle din through 4'h0, 4'hF, 4'h5 over 8 cycles -> q stays 4'hA.
- Back-to-back: load_en=1 for 3 edges with din=4'h3, 4'hC, 4'h9 -> q follows 4'h3, 4'hC, 4'h9 one cycle later each.
- Mid-op reset: q=4'h9, assert rst_n=0 between edges -> q=4'h0 asynchronously. Release and load 4'h6 -> q=4'h6.
- PIPO_SHIFT_EN: load 4'b0001, then shift_en=1 with ser_in=1 for 3 edges -> q=0011, 0111, 1111, and ser_out=1 after the 3rd edge. Asserting load_en=1 with shift_en=1 and din=4'h2 gives q=4'h2 (load priority).
